fb_port_arbiter: RTL and testbench
==================================

// Module: fb_port_arbiter
// PURPOSE
//   Shares the single-port framebuffer sram between the VGA scanout (reads) and the
//   metaball renderer (pixel writes). Scanout reads have absolute priority; renderer
//   writes are buffered in a FIFO and drained into sram on cycles with no read.
//   Sits directly upstream of sram: drives its i_addr/i_write/i_data and consumes o_data.
// PARAMETERS
//   ADDR_WIDTH  16  framebuffer address width; matches sram ADDR_WIDTH
//   DATA_WIDTH  8   pixel width; matches sram DATA_WIDTH
//   FIFO_AW     4   log2 of write FIFO depth (depth = 2**FIFO_AW = 16)
// PORTS
//   i_clk         in   1              system clock, all logic on rising edge
//   i_rst_n       in   1              asynchronous active-low reset
//   i_rd_req      in   1              scanout read request, this cycle
//   i_rd_addr     in   ADDR_WIDTH     scanout read address
//   o_rd_valid    out  1              o_rd_data valid, 3 cycles after i_rd_req
//   o_rd_data     out  DATA_WIDTH     pixel returned to scanout
//   i_wr_valid    in   1              renderer write request
//   o_wr_ready    out  1              FIFO can accept (= !full)
//   i_wr_addr     in   ADDR_WIDTH     renderer pixel address
//   i_wr_data     in   DATA_WIDTH     renderer pixel value
//   o_sram_addr   out  ADDR_WIDTH     to sram i_addr (registered)
//   o_sram_write  out  1              to sram i_write (registered)
//   o_sram_data   out  DATA_WIDTH     to sram i_data (registered)
//   i_sram_data   in   DATA_WIDTH     from sram o_data
//   o_fifo_level  out  FIFO_AW+1      entries currently queued, 0..2**FIFO_AW
//   o_stall_cnt   out  16             saturating count of cycles i_wr_valid && !o_wr_ready
// BEHAVIOUR
//   - Reset (i_rst_n low, async): FIFO emptied, read pipeline cleared; all registered
//     outputs 0; o_wr_ready = 1, o_fifo_level = 0, o_stall_cnt = 0. Queued writes lost.
//   - Write accept: push {addr,data} when i_wr_valid && o_wr_ready. o_wr_ready is
//     combinational !full; no pass-through when full, even if a pop occurs that cycle.
//   - Issue, per cycle, registered onto sram port:
//     i_rd_req=1          -> o_sram_addr<=i_rd_addr, o_sram_write<=0 (FIFO not popped)
//     else FIFO non-empty -> pop head; o_sram_addr/o_sram_data<=head, o_sram_write<=1
//     else                -> o_sram_write<=0; o_sram_addr, o_sram_data hold
//   - Push and pop same cycle: level unchanged. Level counts 0..16; pointers wrap mod 16.
//   - Writes retire in FIFO order; each write hits sram 2 cycles after its pop cycle's
//     preceding edge (1 cycle issue register + sram edge).
//   - Read pipeline: i_rd_req at cycle t -> sram sees address t+1 -> sram o_data t+2 ->
//     o_rd_data registered, o_rd_valid=1 at t+3. Back-to-back reads give one result per
//     cycle. o_rd_data holds last value when o_rd_valid=0.
//   - Coherency: a read to an address with a write still queued returns the old value;
//     renderer/scanout ordering is the system's responsibility. No forwarding.
//   - o_stall_cnt saturates at 16'hFFFF; never wraps.
//   - Starvation is permitted: continuous i_rd_req blocks all drains indefinitely.
// TESTING
//   1 Reset: release i_rst_n -> o_wr_ready=1, o_fifo_level=0, o_sram_write=0, o_rd_valid=0.
//   2 Idle writes (0x0010,AA),(0x0011,BB),(0x0012,CC) back-to-back, no reads -> sram
//     model receives exactly those 3 writes, in order, on 3 consecutive cycles.
//   3 i_rd_req held 20 cycles while pushing 18 writes -> level reaches 16, o_wr_ready=0,
//     o_stall_cnt=2, zero sram writes; after i_rd_req drops, 16 writes drain in 16 cycles.
//   4 sram preloaded 0x0100=5A; i_rd_req addr 0x0100 at cycle t -> o_rd_valid=1,
//     o_rd_data=5A at t+3 only; 4 consecutive reads -> 4 consecutive valid results.
//   5 Level 8 mid-drain, pull i_rst_n low between edges -> outputs 0 immediately,
//     level 0, no sram write after reset release until new push.
//   6 FIFO full, i_wr_valid held, one drain cycle -> push not taken that cycle,
//     taken the next; level returns to 16; o_stall_cnt +1.

Source files
------------

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares the single-port framebuffer sram between scanout reads (priority) and FIFO-buffered renderer writes
module fb_port_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_AW    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_rd_req,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic                  o_rd_valid,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  output logic                  o_sram_write,
  output logic [DATA_WIDTH-1:0] o_sram_data,
  input  logic [DATA_WIDTH-1:0] i_sram_data,
  output logic [FIFO_AW:0]      o_fifo_level,
  output logic [15:0]           o_stall_cnt
);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int EW    = ADDR_WIDTH + DATA_WIDTH;
  logic [EW-1:0]      mem [DEPTH];
  logic [FIFO_AW-1:0] wptr, rptr;
  logic [FIFO_AW:0]   level;
  logic [1:0]         rd_pipe;
  logic               full, empty, push, pop;
  // level never exceeds DEPTH, so its top bit alone marks full
  assign full         = level[FIFO_AW];
  assign empty        = level == '0;
  assign push         = i_wr_valid && !full;
  assign pop          = !i_rd_req && !empty;
  assign o_wr_ready   = !full;
  assign o_fifo_level = level;
  always_ff @(posedge i_clk)
    if (push) mem[wptr] <= {i_wr_addr, i_wr_data};
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr         <= '0;
      rptr         <= '0;
      level        <= '0;
      rd_pipe      <= '0;
      o_rd_valid   <= 1'b0;
      o_rd_data    <= '0;
      o_sram_addr  <= '0;
      o_sram_write <= 1'b0;
      o_sram_data  <= '0;
      o_stall_cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + FIFO_AW'(1);
      if (pop) rptr <= rptr + FIFO_AW'(1);
      level        <= level + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
      o_sram_write <= pop;
      if (i_rd_req) o_sram_addr <= i_rd_addr;
      else if (pop) {o_sram_addr, o_sram_data} <= mem[rptr];
      // rd_pipe[1] marks the cycle the sram is presenting the requested word
      rd_pipe    <= {rd_pipe[0], i_rd_req};
      o_rd_valid <= rd_pipe[1];
      if (rd_pipe[1]) o_rd_data <= i_sram_data;
      if (i_wr_valid && full && o_stall_cnt != 16'hFFFF) o_stall_cnt <= o_stall_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter: scoreboard bench with an sram model and a queue-based reference of the arbiter
module tb_fb_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_req = 1'b0, wr_valid = 1'b0;
  logic [15:0] rd_addr = '0, wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        rd_valid, wr_ready, sram_write;
  logic [7:0]  rd_data, sram_data, sram_q;
  logic [15:0] sram_addr, stall_cnt;
  logic [4:0]  fifo_level;

  fb_port_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_valid(rd_valid), .o_rd_data(rd_data),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .o_sram_addr(sram_addr), .o_sram_write(sram_write), .o_sram_data(sram_data),
    .i_sram_data(sram_q), .o_fifo_level(fifo_level), .o_stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  logic [7:0] smem [65536];
  logic [7:0] ref_mem [65536];
  always @(posedge clk) begin
    if (sram_write) smem[sram_addr] <= sram_data;
    sram_q <= smem[sram_addr];
  end

  typedef struct {logic [15:0] a; logic [7:0] d;} wr_t;
  typedef struct {logic [15:0] a; logic [7:0] d; int due;} ev_t;
  wr_t mfifo[$];
  ev_t exp_wr[$];
  ev_t exp_rd[$];
  int  cyc = 0, mstall = 0, vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // Reference: one sram operation per cycle in issue order; reads win, else the oldest queued write drains
  task automatic cycle(input logic rr, input logic [15:0] ra, input logic wv, input logic [15:0] wa, input logic [7:0] wd);
    logic acc;
    wr_t  w;
    @(negedge clk);
    #1;
    rd_req = rr; rd_addr = ra; wr_valid = wv; wr_addr = wa; wr_data = wd;
    @(posedge clk);
    cyc++;
    acc = wv && mfifo.size() < 16;
    if (wv && mfifo.size() == 16 && mstall < 65535) mstall++;
    if (rr) exp_rd.push_back('{a: ra, d: ref_mem[ra], due: cyc + 2});
    else if (mfifo.size() > 0) begin
      w = mfifo.pop_front();
      ref_mem[w.a] = w.d;
      exp_wr.push_back('{a: w.a, d: w.d, due: cyc});
    end
    if (acc) mfifo.push_back('{a: wa, d: wd});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, '0);
  endtask

  // Asserted between edges, right after a modelled edge; the write registered on that edge never reaches sram
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_sram_write", sram_write, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_sram_addr", sram_addr, 0);
    chk("rst_sram_data", sram_data, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_wr_ready", wr_ready, 1);
    mfifo.delete(); exp_wr.delete(); exp_rd.delete(); mstall = 0;
    rd_req = 1'b0; wr_valid = 1'b0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = smem[i];
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  always @(negedge clk) if (rst_n) begin
    ev_t e;
    chk("level", fifo_level, mfifo.size());
    chk("wr_ready", wr_ready, mfifo.size() < 16);
    chk("stall_cnt", stall_cnt, mstall);
    if (sram_write) begin
      if (exp_wr.size() == 0) fail("unexpected_sram_write");
      else begin
        e = exp_wr.pop_front();
        chk("sram_addr", sram_addr, e.a);
        chk("sram_data", sram_data, e.d);
        chk("sram_write_cycle", cyc, e.due);
      end
    end else if (exp_wr.size() > 0 && exp_wr[0].due <= cyc) begin
      fail("missing_sram_write");
      void'(exp_wr.pop_front());
    end
    if (rd_valid) begin
      if (exp_rd.size() == 0) fail("unexpected_rd_valid");
      else begin
        e = exp_rd.pop_front();
        chk("rd_data", rd_data, e.d);
        chk("rd_cycle", cyc, e.due);
      end
    end else if (exp_rd.size() > 0 && exp_rd[0].due <= cyc) begin
      fail("missing_rd_valid");
      void'(exp_rd.pop_front());
    end
  end

  initial begin
    for (int i = 0; i < 65536; i++) smem[i] = 8'($urandom);
    smem[16'h0100] = 8'h5A;
    for (int i = 0; i < 65536; i++) ref_mem[i] = smem[i];
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #2;
    chk("t1_wr_ready", wr_ready, 1);
    chk("t1_level", fifo_level, 0);
    chk("t1_sram_write", sram_write, 0);
    chk("t1_rd_valid", rd_valid, 0);
    // idle writes drain on consecutive cycles
    cycle(1'b0, '0, 1'b1, 16'h0010, 8'hAA);
    cycle(1'b0, '0, 1'b1, 16'h0011, 8'hBB);
    cycle(1'b0, '0, 1'b1, 16'h0012, 8'hCC);
    idle(5);
    // reads hold the port while the FIFO fills and stalls
    for (int i = 0; i < 20; i++)
      cycle(1'b1, 16'($urandom), i < 18, 16'($urandom_range(16'h1000, 16'hFFFF)), 8'($urandom));
    #2 chk("t3_stall", stall_cnt, 2);
    chk("t3_level", fifo_level, 16);
    idle(20);
    cycle(1'b1, 16'h0100, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'($urandom), 1'b0, '0, '0);
    idle(5);
    // reset while the queue is half full and draining
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 16'($urandom), 1'b1, 16'($urandom_range(16'h1000, 16'hFFFF)), 8'($urandom));
    idle(2);
    do_reset();
    idle(6);
    // full queue, held push, single drain slot
    for (int i = 0; i < 16; i++) cycle(1'b1, 16'($urandom), 1'b1, 16'(16'h2000 + i), 8'($urandom));
    cycle(1'b1, 16'($urandom), 1'b1, 16'h3000, 8'h11);
    cycle(1'b0, '0, 1'b1, 16'h3000, 8'h11);
    cycle(1'b1, 16'($urandom), 1'b1, 16'h3000, 8'h11);
    cycle(1'b1, 16'($urandom), 1'b0, '0, '0);
    idle(20);
    // random traffic on a small address window to mix reads and queued writes
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 99) < 50, 16'($urandom_range(0, 63)), $urandom_range(0, 99) < 60,
            16'($urandom_range(0, 63)), 8'($urandom));
    idle(40);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
